// File: rtl/arith_rr_sequencer_if.sv
// Bundles the two requester command ports and the tagged response port of
// arith_rr_sequencer. The slave modport is the sequencer's view; the master
// modport is the view of the requesters plus the response consumer.
interface arith_rr_sequencer_if #(
    parameter int WIDTH = 8
);

    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_div0;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_div0
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_div0
    );

endinterface

// File: rtl/arith_rr_sequencer.sv
// arith_rr_sequencer: one iterative arithmetic engine (ADD, SUB, shift-add
// MUL, restoring DIV) shared by two requesters through a round-robin arbiter.
// A three-state FSM (IDLE/EXEC/DONE) sequences the datapath and returns a
// tagged, registered result over a valid/ready response port.
// Optional feature macro ARITH_RR_STATS_EN adds per-requester saturating
// completed-operation counters stat_ops0/stat_ops1 of CNT_W bits.
module arith_rr_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    arith_rr_sequencer_if.slave bus
`ifdef ARITH_RR_STATS_EN
    ,
    output logic [CNT_W-1:0]    stat_ops0,
    output logic [CNT_W-1:0]    stat_ops1
`endif
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int ITER_W = $clog2(WIDTH + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } stateT;

    stateT            state_q, state_d;
    logic             lastGrant_q;
    logic [ITER_W-1:0] iter_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;

    logic             rspValid_q;
    logic             rspId_q;
    logic [WIDTH-1:0] rspLo_q;
    logic [WIDTH-1:0] rspHi_q;
    logic             rspDiv0_q;

    logic             grant0, grant1;
    logic             ready0, ready1;
    logic             accept;
    logic             acceptId;
    logic [1:0]       selOp;
    logic [WIDTH-1:0] selA;
    logic [WIDTH-1:0] selB;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH:0]   divDiff;
    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   subDiff;
    logic             divByZero;
    logic             longOp;
    logic             execDone;
    logic             rspHandshake;
    logic [WIDTH-1:0] resLo;
    logic [WIDTH-1:0] resHi;
    logic             resDiv0;

    // Round-robin arbitration: a lone requester always wins, a tie goes to
    // whoever was not granted last; readies only open while the engine idles.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | lastGrant_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~lastGrant_q);
        ready0 = (state_q == IDLE) & grant0;
        ready1 = (state_q == IDLE) & grant1;
    end

    assign accept   = ready0 | ready1;
    assign acceptId = ready1;
    assign selOp    = acceptId ? bus.req1_op : bus.req0_op;
    assign selA     = acceptId ? bus.req1_a  : bus.req0_a;
    assign selB     = acceptId ? bus.req1_b  : bus.req0_b;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    // One step of the iterative datapath: shift-add for MUL keeps the running
    // high half in accHi and the unconsumed multiplier bits in accLo; restoring
    // divide keeps the partial remainder in accHi and shifts quotient bits into accLo.
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, a_q} : '0);
        divTrial = {accHi_q, accLo_q[WIDTH-1]};
        divDiff  = divTrial - {1'b0, b_q};
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        if (op_q == OP_MUL) begin
            accHi_d = mulSum[WIDTH:1];
            accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
        end else if (op_q == OP_DIV) begin
            if (divDiff[WIDTH]) begin
                accHi_d = divTrial[WIDTH-1:0];
                accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
            end else begin
                accHi_d = divDiff[WIDTH-1:0];
                accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Result selection for the cycle in which EXEC finishes; single-cycle ops
    // and divide-by-zero bypass the iteration entirely.
    always_comb begin
        addSum    = {1'b0, a_q} + {1'b0, b_q};
        subDiff   = {1'b0, a_q} - {1'b0, b_q};
        divByZero = (op_q == OP_DIV) && (b_q == '0);
        longOp    = (op_q == OP_MUL) || ((op_q == OP_DIV) && !divByZero);
        execDone  = !longOp || (iter_q == LAST_ITER);
        resLo     = '0;
        resHi     = '0;
        resDiv0   = 1'b0;
        case (op_q)
            OP_ADD: begin
                resLo = addSum[WIDTH-1:0];
                resHi = {{(WIDTH-1){1'b0}}, addSum[WIDTH]};
            end
            OP_SUB: begin
                resLo = subDiff[WIDTH-1:0];
                resHi = {{(WIDTH-1){1'b0}}, subDiff[WIDTH]};
            end
            OP_MUL: begin
                resLo = accLo_d;
                resHi = accHi_d;
            end
            default: begin
                if (divByZero) begin
                    resLo   = '1;
                    resHi   = a_q;
                    resDiv0 = 1'b1;
                end else begin
                    resLo = accLo_d;
                    resHi = accHi_d;
                end
            end
        endcase
    end

    assign rspHandshake = rspValid_q & bus.rsp_ready;

    // Next-state logic: accept starts execution, completion parks the result
    // in DONE, and the consumer's handshake frees the engine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)       state_d = EXEC;
            EXEC:    if (execDone)     state_d = DONE;
            DONE:    if (rspHandshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture on accept and accumulator/iteration updates during EXEC;
    // operands are held privately so requester port changes cannot disturb the op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q <= 1'b1;
            iter_q      <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            accHi_q     <= '0;
            accLo_q     <= '0;
        end else if (accept) begin
            lastGrant_q <= acceptId;
            iter_q      <= '0;
            op_q        <= selOp;
            a_q         <= selA;
            b_q         <= selB;
            id_q        <= acceptId;
            accHi_q     <= '0;
            accLo_q     <= (selOp == OP_DIV) ? selA : selB;
        end else if (state_q == EXEC) begin
            iter_q  <= iter_q + ITER_W'(1);
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
        end
    end

    // Response registers: loaded when EXEC completes and held untouched until
    // the consumer takes them, so back-pressure never changes the fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspValid_q <= 1'b0;
            rspId_q    <= 1'b0;
            rspLo_q    <= '0;
            rspHi_q    <= '0;
            rspDiv0_q  <= 1'b0;
        end else if ((state_q == EXEC) && execDone) begin
            rspValid_q <= 1'b1;
            rspId_q    <= id_q;
            rspLo_q    <= resLo;
            rspHi_q    <= resHi;
            rspDiv0_q  <= resDiv0;
        end else if (rspHandshake) begin
            rspValid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_id    = rspId_q;
    assign bus.rsp_lo    = rspLo_q;
    assign bus.rsp_hi    = rspHi_q;
    assign bus.rsp_div0  = rspDiv0_q;

`ifdef ARITH_RR_STATS_EN
    logic [CNT_W-1:0] statOps0_q;
    logic [CNT_W-1:0] statOps1_q;

    // Per-requester completed-operation counters, bumped on each response
    // handshake and pinned at all ones once full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statOps0_q <= '0;
            statOps1_q <= '0;
        end else if (rspHandshake) begin
            if (!rspId_q && (statOps0_q != '1)) begin
                statOps0_q <= statOps0_q + CNT_W'(1);
            end
            if (rspId_q && (statOps1_q != '1)) begin
                statOps1_q <= statOps1_q + CNT_W'(1);
            end
        end
    end

    assign stat_ops0 = statOps0_q;
    assign stat_ops1 = statOps1_q;
`else
    // Without statistics CNT_W sizes nothing; referencing it here keeps the
    // parameter list identical across both builds.
    if (CNT_W < 1) begin : gNoStatCounters
    end
`endif

endmodule

// File: tb/tb_arith_rr_sequencer.sv
// Self-checking bench for arith_rr_sequencer: directed and randomized
// operations compared against a plain-arithmetic reference model.
module tb_arith_rr_sequencer;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         div0;
        int           lat;
    } expT;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   lastGrant;
    int   statModel [2];

    arith_rr_sequencer_if #(.WIDTH(W)) bus ();

`ifdef ARITH_RR_STATS_EN
    logic [CNT_W-1:0] statOps0;
    logic [CNT_W-1:0] statOps1;
`endif

    arith_rr_sequencer #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef ARITH_RR_STATS_EN
        ,
        .stat_ops0 (statOps0),
        .stat_ops1 (statOps1)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a DUT that stalls the sequence.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired before the sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    // Reference arithmetic straight from the operation definitions.
    function automatic expT refModel(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        expT r;
        int unsigned ua, ub, full, p;
        ua = a;
        ub = b;
        full = 1 << W;
        r.div0 = 1'b0;
        r.lat  = 1;
        case (op)
            2'd0: begin
                r.lo = W'((ua + ub) % full);
                r.hi = W'((ua + ub) / full);
            end
            2'd1: begin
                r.lo = W'((ua + full - ub) % full);
                r.hi = (ua < ub) ? W'(1) : W'(0);
            end
            2'd2: begin
                p    = ua * ub;
                r.lo = W'(p % full);
                r.hi = W'(p / full);
                r.lat = W;
            end
            default: begin
                if (ub == 0) begin
                    r.lo   = W'(full - 1);
                    r.hi   = a;
                    r.div0 = 1'b1;
                end else begin
                    r.lo  = W'(ua / ub);
                    r.hi  = W'(ua % ub);
                    r.lat = W;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic readyOf(input int id);
        return (id == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    task automatic applyStimulus(input int id, input logic v, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            bus.req0_valid = v;
            bus.req0_op    = op;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = v;
            bus.req1_op    = op;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic noteHandshake(input int id);
        if (statModel[id] < (1 << CNT_W) - 1) statModel[id]++;
`ifdef ARITH_RR_STATS_EN
        checkOutput("statOps0", 32'(statOps0), 32'(statModel[0]));
        checkOutput("statOps1", 32'(statOps1), 32'(statModel[1]));
`endif
    endtask

    // One complete transaction from a lone requester: grant, latency, fields,
    // optional back-pressure, handshake.
    task automatic runOp(input int id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int holdCycles, input bit earlyReady);
        expT e;
        int  edges;
        e = refModel(op, a, b);
        applyStimulus(id, 1'b1, op, a, b);
        #1;
        checkOutput("grantSole", 32'(readyOf(id)), 32'd1);
        checkOutput("otherReady", 32'(readyOf(1 - id)), 32'd0);
        @(posedge clk);
        #1;
        lastGrant = id;
        applyStimulus(id, 1'b0, 2'($urandom), W'($urandom), W'($urandom));
        bus.rsp_ready = earlyReady;
        edges = 0;
        while (bus.rsp_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("latency", 32'(edges), 32'(e.lat));
        checkOutput("rspLo", 32'(bus.rsp_lo), 32'(e.lo));
        checkOutput("rspHi", 32'(bus.rsp_hi), 32'(e.hi));
        checkOutput("rspId", 32'(bus.rsp_id), 32'(id));
        checkOutput("rspDiv0", 32'(bus.rsp_div0), 32'(e.div0));
        if (!earlyReady) begin
            repeat (holdCycles) begin
                @(posedge clk);
                #1;
                checkOutput("holdStable",
                            32'({bus.rsp_valid, bus.rsp_id, bus.rsp_div0, bus.rsp_lo, bus.rsp_hi}),
                            32'({1'b1, 1'(id), e.div0, e.lo, e.hi}));
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("rspDrop", 32'(bus.rsp_valid), 32'd0);
        noteHandshake(id);
    endtask

    initial begin
        logic [W-1:0] curA [2];
        logic [W-1:0] curB [2];
        expT          e;
        int           expId;
        bit           lateSeen;

        checks = 0;
        errors = 0;
        lastGrant = 1;
        statModel[0] = 0;
        statModel[1] = 0;
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        applyStimulus(0, 1'b0, 2'd0, '0, '0);
        applyStimulus(1, 1'b0, 2'd0, '0, '0);

        // Reset values.
        #2;
        checkOutput("resetRsp",
                    32'({bus.rsp_valid, bus.rsp_id, bus.rsp_div0, bus.rsp_lo, bus.rsp_hi}), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both requesters valid with back-to-back ADDs: grants alternate from 0.
        for (int i = 0; i < 2; i++) begin
            curA[i] = W'($urandom);
            curB[i] = W'($urandom);
            applyStimulus(i, 1'b1, 2'd0, curA[i], curB[i]);
        end
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            expId = (lastGrant == 0) ? 1 : 0;
            #1;
            checkOutput("rrGrant", 32'(readyOf(expId)), 32'd1);
            checkOutput("rrLoser", 32'(readyOf(1 - expId)), 32'd0);
            @(posedge clk);
            #1;
            lastGrant = expId;
            e = refModel(2'd0, curA[expId], curB[expId]);
            curA[expId] = W'($urandom);
            curB[expId] = W'($urandom);
            applyStimulus(expId, 1'b1, 2'd0, curA[expId], curB[expId]);
            checkOutput("execReadys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("rrValid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("rrLo", 32'(bus.rsp_lo), 32'(e.lo));
            checkOutput("rrHi", 32'(bus.rsp_hi), 32'(e.hi));
            checkOutput("rrId", 32'(bus.rsp_id), 32'(expId));
            if (t == 2) begin
                bus.rsp_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    checkOutput("bpStable",
                                32'({bus.rsp_valid, bus.rsp_id, bus.rsp_lo, bus.rsp_hi}),
                                32'({1'b1, 1'(expId), e.lo, e.hi}));
                    checkOutput("bpReadys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
                end
                bus.rsp_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            checkOutput("rrDrop", 32'(bus.rsp_valid), 32'd0);
            noteHandshake(expId);
        end
        applyStimulus(0, 1'b0, 2'd0, '0, '0);
        applyStimulus(1, 1'b0, 2'd0, '0, '0);
        bus.rsp_ready = 1'b0;

        // Directed operations including the boundary cases.
        runOp(0, 2'd0, 8'd20, 8'd10, 0, 1'b1);
        runOp(1, 2'd2, 8'd50, 8'd20, 0, 1'b0);
        runOp(0, 2'd3, 8'd15, 8'd4, 0, 1'b0);
        runOp(0, 2'd3, 8'd9, 8'd0, 0, 1'b0);
        runOp(0, 2'd1, 8'd0, 8'd7, 2, 1'b0);
        runOp(1, 2'd2, 8'd255, 8'd255, 3, 1'b0);

        // Randomized operations.
        for (int k = 0; k < 24; k++) begin
            int           rid;
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            rid = int'($urandom_range(1, 0));
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (rop == 2'd3 && $urandom_range(3, 0) == 0) rb = '0;
            runOp(rid, rop, ra, rb, int'($urandom_range(2, 0)), 1'($urandom));
        end

        // Reset in the middle of a multiply abandons it.
        applyStimulus(0, 1'b1, 2'd2, 8'd123, 8'd45);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 2'd0, '0, '0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("resetMidValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("resetMidFields",
                    32'({bus.rsp_id, bus.rsp_div0, bus.rsp_lo, bus.rsp_hi}), 32'd0);
        lastGrant = 1;
        statModel[0] = 0;
        statModel[1] = 0;
`ifdef ARITH_RR_STATS_EN
        checkOutput("statReset", 32'({statOps0, statOps1}), 32'd0);
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        lateSeen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0) lateSeen = 1'b1;
        end
        checkOutput("noLateRsp", 32'(lateSeen), 32'd0);
        runOp(0, 2'd0, 8'd100, 8'd200, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_rr_sequencer.md
Name: arith_rr_sequencer

Overview:
Shares one multi-cycle arithmetic engine (add, subtract, shift-add multiply, restoring divide) between two requesters.
- Each requester issues {op, a, b} over a valid/ready handshake.
- A round-robin arbiter grants one request at a time.
- An FSM sequences the iterative datapath and returns a tagged result over a valid/ready response port.
- Replaces per-operator combinational instances where area matters.

Parameters:
WIDTH, 8, operand width; also the MUL/DIV iteration count.
CNT_W, 16, width of the optional statistics counters.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
req0_a  in  WIDTH  operand a (unsigned)
req0_b  in  WIDTH  operand b (unsigned)
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that issued this result
rsp_lo  out  WIDTH  sum / diff / product[WIDTH-1:0] / quotient
rsp_hi  out  WIDTH  carry (bit0) / borrow (bit0) / product[2W-1:W] / remainder
rsp_div0  out  1  DIV with b==0

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_div0 = 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Iteration counter = 0.
- States:
  - IDLE -> EXEC on accept.
  - EXEC -> DONE when the operation completes.
  - DONE -> IDLE on rsp_valid & rsp_ready.
- Arbitration, in IDLE only (combinational):
  - Grant the sole valid requester.
  - If both requesters are valid, grant the one != last_grant.
  - reqN_ready = IDLE & grantN.
  - Accept = reqN_valid & reqN_ready. On accept, latch op/a/b/id and set last_grant=id.
  - Both ready signals are 0 in EXEC and DONE.
- Execution latency, counted in edges from the accept edge to the edge where rsp_valid rises:
  - ADD/SUB: 1. Results: lo=(a±b) mod 2^W; hi={0..,carry} for ADD, hi={0..,borrow} for SUB (borrow = a<b).
  - MUL: WIDTH. One shift-add iteration per cycle on a 2W accumulator; {hi,lo} = a*b.
  - DIV: WIDTH. One restoring-divide iteration per cycle; lo=a/b, hi=a%b.
  - DIV with b==0: 1 edge. lo = all ones, hi = a, rsp_div0 = 1.
- Response:
  - rsp_* registered, stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid falls on the edge where rsp_ready=1.
  - The next grant can occur in the following IDLE cycle: one bubble, so peak throughput is one op per latency+2 cycles.
  - rsp_div0 = 0 for every op except DIV with b==0.
- Boundaries:
  - Operand changes on req ports after accept have no effect.
  - A requester holding valid while not granted must keep its command stable; it is not dropped.
  - rsp_ready asserted while rsp_valid=0 is ignored.
  - MUL 255*255 gives hi=254, lo=1 with no overflow loss.
- Reset mid-operation: the in-flight op is abandoned and no response is produced. Outputs reach reset values asynchronously.

Optional Feature:
ARITH_RR_STATS_EN
- Defined: adds output ports stat_ops0 and stat_ops1 [CNT_W-1:0].
  - Each counter increments on the response handshake for its rsp_id.
  - Saturates at all ones. Reset to 0.
- Undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- req0 ADD a=20 b=10, rsp_ready=1 -> rsp_valid 1 edge after accept; lo=30, hi=0, rsp_id=0.
- req1 MUL a=50 b=20 -> rsp_valid 8 edges after accept; hi=3, lo=232 (1000); rsp_id=1.
- req0 DIV 15/4 -> lo=3, hi=3, div0=0 after 8 edges. Then DIV 9/0 -> lo=255, hi=9, div0=1 after 1 edge.
- req0 SUB a=0 b=7 -> lo=249, hi=1 (borrow).
- Both valid every cycle with back-to-back ADDs -> grants alternate 0,1,0,1 starting with 0. Hold rsp_ready=0 for 5 cycles -> rsp fields stable and neither ready asserts.
- Assert rst_n=0 mid-MUL (iteration 4) -> rsp_valid=0 immediately and no late response. A new ADD after release completes normally. With ARITH_RR_STATS_EN defined, counters read 0 after reset and increment per handshake.
